// File: rtl/spi_controller_quad.sv
// Quad-lane SPI master (mode 0): one 16-SCK frame per request, opcode/address on lanes 1:0,
// then up to four data bytes in parallel, with read bytes reassembled word-aligned into rdata.
module spi_controller_quad #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  byte_addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        CS_N,
    output logic        SCK,
    output logic [3:0]  COPI,
    input  logic [3:0]  CIPO
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_TRAIL = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 32'd1);

    state_t      state_r, state_s;
    logic [7:0]  div_cnt_r, div_cnt_s;
    logic [3:0]  bit_cnt_r, bit_cnt_s;
    logic        last_r, last_s;
    logic [2:0]  op_r, op_s;
    logic [7:0]  addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [31:0] shadow_r, shadow_s;
    logic        cs_n_r, cs_n_s;
    logic        sck_r, sck_s;
    logic [3:0]  copi_r, copi_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic [31:0] rdata_r, rdata_s;
    logic        phase_end_s;

    function automatic logic op_legal(input logic [2:0] f_op);
        return (f_op[1:0] != 2'b11);
    endfunction

    // Lane values for bit slot f_bit; bit slots 0..7 and 8..15 share the MSB-first index ~f_bit[2:0]
    function automatic logic [3:0] copi_bits(input logic [2:0]  f_op,
                                             input logic [7:0]  f_addr,
                                             input logic [31:0] f_wdata,
                                             input logic [3:0]  f_bit);
        logic [2:0] idx;
        logic [7:0] op_byte;
        logic [7:0] lane_byte;
        logic [3:0] lanes;
        idx       = ~f_bit[2:0];
        op_byte   = {5'b00000, f_op};
        lanes     = 4'b0000;
        lane_byte = 8'h00;
        if (!f_bit[3]) begin
            lanes[0] = op_byte[idx];
            lanes[1] = f_addr[idx];
        end else if (f_op[2]) begin
            for (int k = 0; k < 4; k++) begin
                lane_byte = f_wdata[8*k +: 8];
                lanes[k]  = lane_byte[idx];
            end
            case (f_op[1:0])
                2'b00:   lanes[3:1] = 3'b000;
                2'b01:   lanes[3:2] = 2'b00;
                default: lanes      = lanes;
            endcase
        end else begin
            lanes = 4'b0000;
        end
        return lanes;
    endfunction

    // State register and all registered outputs; reset drives the pins idle at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            div_cnt_r <= 8'd0;
            bit_cnt_r <= 4'd0;
            last_r    <= 1'b0;
            op_r      <= 3'd0;
            addr_r    <= 8'd0;
            wdata_r   <= 32'd0;
            shadow_r  <= 32'd0;
            cs_n_r    <= 1'b1;
            sck_r     <= 1'b0;
            copi_r    <= 4'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            state_r   <= state_s;
            div_cnt_r <= div_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            last_r    <= last_s;
            op_r      <= op_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            shadow_r  <= shadow_s;
            cs_n_r    <= cs_n_s;
            sck_r     <= sck_s;
            copi_r    <= copi_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
            rdata_r   <= rdata_s;
        end
    end

    // Next-state and next-output logic; every non-idle state lasts CLK_DIV cycles
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        last_s      = last_r;
        op_s        = op_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        shadow_s    = shadow_r;
        cs_n_s      = cs_n_r;
        sck_s       = sck_r;
        copi_s      = copi_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        err_s       = 1'b0;
        rdata_s     = rdata_r;
        phase_end_s = (div_cnt_r == DIV_LAST);

        if (state_r == ST_IDLE) begin
            div_cnt_s = 8'd0;
        end else if (phase_end_s) begin
            div_cnt_s = 8'd0;
        end else begin
            div_cnt_s = div_cnt_r + 8'd1;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_s    = op;
                    addr_s  = byte_addr;
                    wdata_s = wdata;
                    if (op_legal(op)) begin
                        state_s   = ST_LEAD;
                        cs_n_s    = 1'b0;
                        sck_s     = 1'b0;
                        busy_s    = 1'b1;
                        bit_cnt_s = 4'd0;
                        last_s    = 1'b0;
                        copi_s    = copi_bits(op, byte_addr, wdata, 4'd0);
                    end else begin
                        done_s = 1'b1;
                        err_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (phase_end_s) begin
                    state_s = ST_HIGH;
                    sck_s   = 1'b1;
                end else begin
                    state_s = ST_LEAD;
                end
            end
            ST_HIGH: begin
                if (phase_end_s) begin
                    state_s   = ST_LOW;
                    sck_s     = 1'b0;
                    bit_cnt_s = bit_cnt_r + 4'd1;
                    // After the 16th rise there is no further bit to present
                    if (bit_cnt_r == 4'd15) begin
                        last_s = 1'b1;
                        copi_s = 4'd0;
                    end else begin
                        copi_s = copi_bits(op_r, addr_r, wdata_r, bit_cnt_r + 4'd1);
                    end
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (phase_end_s) begin
                    if (last_r) begin
                        state_s = ST_TRAIL;
                        cs_n_s  = 1'b1;
                        copi_s  = 4'd0;
                    end else begin
                        state_s = ST_HIGH;
                        sck_s   = 1'b1;
                        // Rises 9..16 carry read data, one bit per lane, MSB first
                        if (bit_cnt_r[3]) begin
                            for (int k = 0; k < 4; k++) begin
                                shadow_s[8*k +: 8] = {shadow_r[8*k +: 7], CIPO[k]};
                            end
                        end else begin
                            shadow_s = shadow_r;
                        end
                    end
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_TRAIL: begin
                if (phase_end_s) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    if (!op_r[2]) begin
                        case (op_r[1:0])
                            2'b00:   rdata_s = {24'd0, shadow_r[7:0]};
                            2'b01:   rdata_s = {16'd0, shadow_r[15:0]};
                            default: rdata_s = shadow_r;
                        endcase
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else begin
                    state_s = ST_TRAIL;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cs_n_s  = 1'b1;
                sck_s   = 1'b0;
                copi_s  = 4'd0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;
    assign rdata = rdata_r;
    assign CS_N  = cs_n_r;
    assign SCK   = sck_r;
    assign COPI  = copi_r;

endmodule
